parking_slot_ctrl: RTL and testbench
====================================

Name: parking_slot_ctrl

Overview:
- Parametrised parking-lot slot manager that replaces the fixed 16-switch, 5-button controller path.
- Synchronises NUM_SLOTS occupancy sensors and debounces the five navigation buttons.
- Moves a slot cursor and runs a reserve/release/confirm state machine; a reserved bit clears automatically when a car arrives in that slot.
- Drives per-slot LEDs plus a registered free-slot count for the seven-segment driver.

Parameters:
- NUM_SLOTS, 16, number of parking slots (2..64).
- DEB_CYCLES, 500000, stable cycles required before a button level is accepted; use 4 in simulation.
- TIMEOUT_CYCLES, 50000000, cycles a pending request waits for confirm before it is cancelled.
- BLINK_BIT, 23, blink-counter bit that drives the cursor blink (see Optional Feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- btn_l  in  1  raw button, cursor left.
- btn_r  in  1  raw button, cursor right.
- btn_u  in  1  raw button, request reserve.
- btn_d  in  1  raw button, request release.
- btn_c  in  1  raw button, confirm.
- sensor  in  NUM_SLOTS  raw occupancy, 1 = car present.
- led  out  NUM_SLOTS  slot status display.
- reserved  out  NUM_SLOTS  reservation flags.
- cursor  out  $clog2(NUM_SLOTS)  selected slot index.
- free_count  out  $clog2(NUM_SLOTS+1)  number of slots neither occupied nor reserved.
- state  out  2  FSM state: 0 IDLE, 1 RES_PEND, 2 REL_PEND.
- err  out  1  one-cycle pulse on a rejected confirm.

Behaviour:
- Reset (rst=0, asynchronous):
  - cursor=0, reserved=0, state=IDLE, err=0, led=0, free_count=NUM_SLOTS.
  - All synchronisers, debounce counters and the timeout counter clear.
- Buttons:
  - Each button goes through a 2-FF synchroniser.
  - The debounced level updates only after the synchronised level differs from it for DEB_CYCLES consecutive cycles; the counter restarts on any bounce.
  - A rising edge of the debounced level produces a one-cycle pulse. Holding a button gives exactly one pulse.
- Sensors: 2-FF synchroniser per bit; sens_s is the synchronised vector.
- Simultaneous pulses in one cycle: only the highest-priority pulse acts. Priority is C > U > D > L > R; the rest are dropped.
- Cursor movement:
  - L: cursor decrements, wrapping 0 -> NUM_SLOTS-1.
  - R: cursor increments, wrapping NUM_SLOTS-1 -> 0.
  - Cursor update latency is 1 cycle after the pulse.
- FSM:
  - IDLE: U -> RES_PEND; D -> REL_PEND; C -> err pulse, stay in IDLE.
  - RES_PEND, C pressed:
    - If sens_s[cursor]=0 and reserved[cursor]=0: set reserved[cursor], go to IDLE.
    - Otherwise: err pulse, go to IDLE.
  - REL_PEND, C pressed:
    - If reserved[cursor]=1: clear it, go to IDLE.
    - Otherwise: err pulse, go to IDLE.
  - Any pending state:
    - L or R moves the cursor and cancels to IDLE.
    - U or D reselects the request (U -> RES_PEND, D -> REL_PEND) and reloads the timeout.
    - Timeout counter reaching TIMEOUT_CYCLES -> IDLE, no err.
- Auto-clear:
  - Each cycle, for every i with sens_s[i]=1 and reserved[i]=1, reserved[i] clears.
  - Auto-clear overrides a same-cycle confirm on that slot; for a reserve confirm that case already raises err because the slot is occupied.
- led = sens_s | reserved, registered, 1-cycle latency.
- free_count = NUM_SLOTS - popcount(sens_s | reserved):
  - Registered, 1-cycle latency after the reserved/sens_s change.
  - Never wraps; the range is 0..NUM_SLOTS.
- err is high for exactly one cycle, registered alongside the state update.
- Asserting reset mid-request drops the pending request and all reservations.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- Defined:
  - A free-running counter is added.
  - led[cursor] is XORed with counter[BLINK_BIT] while state != IDLE, and forced to 1 while state == IDLE.
  - Other LED bits are unchanged.
- Undefined: no blink counter; led is exactly sens_s | reserved.

Test Plan (NUM_SLOTS=16, DEB_CYCLES=4, TIMEOUT_CYCLES=64, CURSOR_BLINK_EN undefined):
- Reset then release; press L once -> cursor=15. Press R twice -> cursor=1. free_count=16.
- Cursor=3, sensor=0; press U then C -> reserved=16'h0008, led=16'h0008, free_count=15, err never high.
- reserved[3]=1; drive sensor[3]=1 -> after sync plus 1 cycle: reserved[3]=0, led[3]=1, free_count=15.
- Cursor=5, sensor[5]=1; press U then C -> err one-cycle pulse, reserved unchanged, state=IDLE. Then press D then C -> err pulse.
- Press U, wait 70 cycles -> state returns to IDLE with no err. Press U then R -> state=IDLE, cursor advanced by 1.
- Bounce btn_c 1-0-1 with 2-cycle periods, then hold 10 cycles -> exactly one confirm pulse. Pulse btn_u and btn_l in the same cycle -> only RES_PEND entered, cursor unchanged.

Source files
------------

// File: rtl/parking_slot_ctrl.sv
// parking_slot_ctrl: parametrised parking-lot slot manager.
//   Synchronises NUM_SLOTS occupancy sensors, debounces five navigation
//   buttons, moves a slot cursor and runs a reserve/release/confirm FSM.
//   A reservation clears itself as soon as a car shows up in that slot.
//
// Optional feature macro: CURSOR_BLINK_EN
//   defined   : led[cursor] blinks (XOR with a free-running counter bit)
//               while a request is pending and is forced on while IDLE.
//   undefined : led is exactly sens_s | reserved.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   btn_l/r     raw buttons, cursor left / right
//   btn_u/d     raw buttons, request reserve / release
//   btn_c       raw button, confirm
//   sensor      raw occupancy, 1 = car present
//   led         registered sens_s | reserved
//   reserved    reservation flags
//   cursor      selected slot index
//   free_count  registered count of slots neither occupied nor reserved
//   state       0 IDLE, 1 RES_PEND, 2 REL_PEND
//   err         one-cycle pulse on a rejected confirm

// Per-button 2-FF synchroniser, debouncer and rising-edge pulse.
//   i_btn   raw button level
//   o_pulse one-cycle pulse on a rising edge of the debounced level
module psc_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    r_sync;
  logic          r_deb;
  logic          r_deb_q;
  logic [DW-1:0] r_cnt;

  // r_cnt counts consecutive cycles where the synchronised level disagrees
  // with the accepted level; any agreement (a bounce) restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_deb   <= 1'b0;
      r_deb_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_deb_q <= r_deb;
      if (r_sync[1] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == DW'(DEB_CYCLES - 1)) begin
        r_deb <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_deb & ~r_deb_q;
endmodule

module parking_slot_ctrl #(
  parameter int NUM_SLOTS      = 16,
  parameter int DEB_CYCLES     = 500000,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int BLINK_BIT      = 23
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn_l,
  input  logic                           btn_r,
  input  logic                           btn_u,
  input  logic                           btn_d,
  input  logic                           btn_c,
  input  logic [NUM_SLOTS-1:0]           sensor,
  output logic [NUM_SLOTS-1:0]           led,
  output logic [NUM_SLOTS-1:0]           reserved,
  output logic [$clog2(NUM_SLOTS)-1:0]   cursor,
  output logic [$clog2(NUM_SLOTS+1)-1:0] free_count,
  output logic [1:0]                     state,
  output logic                           err
);
  localparam int CURW = $clog2(NUM_SLOTS);
  localparam int CW   = $clog2(NUM_SLOTS + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NBTN = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RES  = 2'd1,
    S_REL  = 2'd2
  } state_t;

  // ---------------- buttons ----------------
  // bit order: 4 C, 3 U, 2 D, 1 L, 0 R (descending priority)
  logic [NBTN-1:0] w_btn_raw;
  logic [NBTN-1:0] w_pulse;

  assign w_btn_raw = {btn_c, btn_u, btn_d, btn_l, btn_r};

  for (genvar g = 0; g < NBTN; g++) begin : g_deb
    psc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (w_btn_raw[g]),
      .o_pulse (w_pulse[g])
    );
  end

  // Only the highest-priority pulse in a cycle acts.
  logic w_c, w_u, w_d, w_l, w_r;
  assign w_c = w_pulse[4];
  assign w_u = w_pulse[3] & ~w_pulse[4];
  assign w_d = w_pulse[2] & ~|w_pulse[4:3];
  assign w_l = w_pulse[1] & ~|w_pulse[4:2];
  assign w_r = w_pulse[0] & ~|w_pulse[4:1];

  // ---------------- sensors ----------------
  logic [NUM_SLOTS-1:0] r_sens_s1;
  logic [NUM_SLOTS-1:0] r_sens_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sens_s1 <= '0;
      r_sens_s  <= '0;
    end else begin
      r_sens_s1 <= sensor;
      r_sens_s  <= r_sens_s1;
    end
  end

  // ---------------- FSM / cursor / reservations ----------------
  state_t               r_state, w_state_nxt;
  logic [CURW-1:0]      r_cursor, w_cur_nxt;
  logic [NUM_SLOTS-1:0] r_reserved, w_res_nxt;
  logic [TW-1:0]        r_to_cnt;
  logic                 r_err, w_err_nxt;
  logic                 w_to_load;
  logic                 w_to_hit;
  logic                 w_set, w_clr;

  assign w_to_hit = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cursor;
    w_err_nxt   = 1'b0;
    w_to_load   = 1'b0;
    w_set       = 1'b0;
    w_clr       = 1'b0;

    // L/R move the cursor in every state; pending states also cancel below.
    if (w_l)
      w_cur_nxt = (r_cursor == '0) ? CURW'(NUM_SLOTS - 1) : r_cursor - 1'b1;
    else if (w_r)
      w_cur_nxt = (r_cursor == CURW'(NUM_SLOTS - 1)) ? '0 : r_cursor + 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_u) begin
          w_state_nxt = S_RES;
          w_to_load   = 1'b1;
        end else if (w_d) begin
          w_state_nxt = S_REL;
          w_to_load   = 1'b1;
        end else if (w_c) begin
          w_err_nxt = 1'b1;
        end
      end
      S_RES, S_REL: begin
        if (w_c) begin
          w_state_nxt = S_IDLE;
          if (r_state == S_RES) begin
            if (!r_sens_s[r_cursor] && !r_reserved[r_cursor]) w_set = 1'b1;
            else                                              w_err_nxt = 1'b1;
          end else begin
            if (r_reserved[r_cursor]) w_clr = 1'b1;
            else                      w_err_nxt = 1'b1;
          end
        end else if (w_u) begin
          w_state_nxt = S_RES;
          w_to_load   = 1'b1;
        end else if (w_d) begin
          w_state_nxt = S_REL;
          w_to_load   = 1'b1;
        end else if (w_l || w_r) begin
          w_state_nxt = S_IDLE;
        end else if (w_to_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Confirm effect first, then auto-clear on occupied slots so that a car
  // arriving always wins over a same-cycle confirm.
  always_comb begin
    w_res_nxt = r_reserved;
    if (w_set) w_res_nxt[r_cursor] = 1'b1;
    if (w_clr) w_res_nxt[r_cursor] = 1'b0;
    w_res_nxt = w_res_nxt & ~r_sens_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cursor   <= '0;
      r_reserved <= '0;
      r_err      <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cursor   <= w_cur_nxt;
      r_reserved <= w_res_nxt;
      r_err      <= w_err_nxt;
      if (w_state_nxt == S_IDLE || w_to_load) r_to_cnt <= '0;
      else                                     r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // ---------------- display ----------------
  logic [NUM_SLOTS-1:0] w_occ;
  logic [NUM_SLOTS-1:0] w_led_nxt;
  logic [CW-1:0]        w_pop;
  logic [CW-1:0]        w_free;
  logic [NUM_SLOTS-1:0] r_led;
  logic [CW-1:0]        r_free;

  assign w_occ = r_sens_s | r_reserved;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_SLOTS; i++) w_pop = w_pop + CW'(w_occ[i]);
  end

  // w_pop <= NUM_SLOTS, so this never wraps.
  assign w_free = CW'(NUM_SLOTS) - w_pop;

`ifdef CURSOR_BLINK_EN
  logic [BLINK_BIT:0] r_blink;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_blink <= '0;
    else      r_blink <= r_blink + 1'b1;
  end

  always_comb begin
    w_led_nxt = w_occ;
    if (r_state == S_IDLE) w_led_nxt[r_cursor] = 1'b1;
    else                   w_led_nxt[r_cursor] = w_occ[r_cursor] ^ r_blink[BLINK_BIT];
  end
`else
  assign w_led_nxt = w_occ;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led  <= '0;
      r_free <= CW'(NUM_SLOTS);
    end else begin
      r_led  <= w_led_nxt;
      r_free <= w_free;
    end
  end

  assign led        = r_led;
  assign reserved   = r_reserved;
  assign cursor     = r_cursor;
  assign free_count = r_free;
  assign state      = r_state;
  assign err        = r_err;
endmodule

// File: tb/tb_parking_slot_ctrl.sv
// Directed bench for parking_slot_ctrl (NUM_SLOTS=16, DEB_CYCLES=4,
// TIMEOUT_CYCLES=64, blink disabled). Expected values are hand-computed.
module tb_parking_slot_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  btn = '0;  // 4 C, 3 U, 2 D, 1 L, 0 R
  logic [15:0] sensor = '0;
  logic [15:0] led, reserved;
  logic [3:0]  cursor;
  logic [4:0]  free_count;
  logic [1:0]  state;
  logic        err;

  int checks = 0;
  int failures = 0;

  // err monitor: rising-edge count and longest high run
  int   err_pulses = 0;
  int   err_run = 0;
  int   err_max = 0;
  logic err_prev = 1'b0;

  localparam int B_R = 0, B_L = 1, B_D = 2, B_U = 3, B_C = 4;

  parking_slot_ctrl #(
    .NUM_SLOTS(16), .DEB_CYCLES(4), .TIMEOUT_CYCLES(64), .BLINK_BIT(23)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_l(btn[B_L]), .btn_r(btn[B_R]), .btn_u(btn[B_U]),
    .btn_d(btn[B_D]), .btn_c(btn[B_C]),
    .sensor(sensor), .led(led), .reserved(reserved), .cursor(cursor),
    .free_count(free_count), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err) begin
      err_run = err_run + 1;
      if (err_run > err_max) err_max = err_run;
    end else begin
      err_run = 0;
    end
    if (err && !err_prev) err_pulses = err_pulses + 1;
    err_prev = err;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic press(input int idx);
    @(negedge clk); btn[idx] = 1'b1;
    repeat (10) @(negedge clk);
    btn[idx] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (cursor !== 4'd0) begin failures++; $display("FAIL reset_cursor got=%0d exp=0", cursor); end
    checks++; if (reserved !== 16'h0) begin failures++; $display("FAIL reset_reserved got=%h exp=0000", reserved); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL reset_led got=%h exp=0000", led); end
    checks++; if (free_count !== 5'd16) begin failures++; $display("FAIL reset_free got=%0d exp=16", free_count); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cursor;
    press(B_L);
    checks++; if (cursor !== 4'd15) begin failures++; $display("FAIL cursor_wrap_left got=%0d exp=15", cursor); end
    press(B_R); press(B_R);
    checks++; if (cursor !== 4'd1) begin failures++; $display("FAIL cursor_wrap_right got=%0d exp=1", cursor); end
    checks++; if (free_count !== 5'd16) begin failures++; $display("FAIL cursor_free got=%0d exp=16", free_count); end
  endtask

  task automatic test_reserve;
    int e0;
    press(B_R); press(B_R);
    checks++; if (cursor !== 4'd3) begin failures++; $display("FAIL reserve_cursor got=%0d exp=3", cursor); end
    e0 = err_pulses;
    press(B_U);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL reserve_pend got=%0d exp=1", state); end
    press(B_C);
    checks++; if (reserved !== 16'h0008) begin failures++; $display("FAIL reserve_flags got=%h exp=0008", reserved); end
    checks++; if (led !== 16'h0008) begin failures++; $display("FAIL reserve_led got=%h exp=0008", led); end
    checks++; if (free_count !== 5'd15) begin failures++; $display("FAIL reserve_free got=%0d exp=15", free_count); end
    checks++; if (err_pulses !== e0) begin failures++; $display("FAIL reserve_no_err got=%0d exp=%0d", err_pulses, e0); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reserve_idle got=%0d exp=0", state); end
  endtask

  task automatic test_autoclear;
    @(negedge clk); sensor = 16'h0008;
    repeat (4) @(negedge clk);
    checks++; if (reserved !== 16'h0000) begin failures++; $display("FAIL autoclr_flags got=%h exp=0000", reserved); end
    checks++; if (led !== 16'h0008) begin failures++; $display("FAIL autoclr_led got=%h exp=0008", led); end
    checks++; if (free_count !== 5'd15) begin failures++; $display("FAIL autoclr_free got=%0d exp=15", free_count); end
  endtask

  task automatic test_err;
    int e0;
    press(B_R); press(B_R);
    @(negedge clk); sensor = 16'h0028;
    repeat (4) @(negedge clk);
    checks++; if (free_count !== 5'd14) begin failures++; $display("FAIL err_free got=%0d exp=14", free_count); end
    e0 = err_pulses;
    press(B_U); press(B_C);
    checks++; if (err_pulses !== e0 + 1) begin failures++; $display("FAIL err_res_occupied got=%0d exp=%0d", err_pulses, e0 + 1); end
    checks++; if (reserved !== 16'h0) begin failures++; $display("FAIL err_res_flags got=%h exp=0000", reserved); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL err_res_state got=%0d exp=0", state); end
    press(B_D); press(B_C);
    checks++; if (err_pulses !== e0 + 2) begin failures++; $display("FAIL err_rel_unreserved got=%0d exp=%0d", err_pulses, e0 + 2); end
    checks++; if (err_max !== 1) begin failures++; $display("FAIL err_width got=%0d exp=1", err_max); end
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_pulses;
    press(B_U);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL to_pend got=%0d exp=1", state); end
    repeat (70) @(negedge clk);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL to_idle got=%0d exp=0", state); end
    checks++; if (err_pulses !== e0) begin failures++; $display("FAIL to_no_err got=%0d exp=%0d", err_pulses, e0); end
    press(B_U); press(B_R);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL cancel_state got=%0d exp=0", state); end
    checks++; if (cursor !== 4'd6) begin failures++; $display("FAIL cancel_cursor got=%0d exp=6", cursor); end
  endtask

  task automatic test_bounce;
    int e0;
    e0 = err_pulses;
    @(negedge clk); btn[B_C] = 1'b1;
    repeat (2) @(negedge clk); btn[B_C] = 1'b0;
    repeat (2) @(negedge clk); btn[B_C] = 1'b1;
    repeat (10) @(negedge clk); btn[B_C] = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (err_pulses !== e0 + 1) begin failures++; $display("FAIL bounce_pulses got=%0d exp=%0d", err_pulses, e0 + 1); end
  endtask

  task automatic test_priority;
    @(negedge clk); btn[B_U] = 1'b1; btn[B_L] = 1'b1;
    repeat (10) @(negedge clk); btn[B_U] = 1'b0; btn[B_L] = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL prio_state got=%0d exp=1", state); end
    checks++; if (cursor !== 4'd6) begin failures++; $display("FAIL prio_cursor got=%0d exp=6", cursor); end
    repeat (70) @(negedge clk);
  endtask

  task automatic test_release_and_reset;
    int e0;
    @(negedge clk); sensor = 16'h0;
    repeat (4) @(negedge clk);
    checks++; if (free_count !== 5'd16) begin failures++; $display("FAIL rel_free_empty got=%0d exp=16", free_count); end
    press(B_U); press(B_C);
    checks++; if (reserved !== 16'h0040) begin failures++; $display("FAIL rel_setup got=%h exp=0040", reserved); end
    e0 = err_pulses;
    press(B_D); press(B_C);
    checks++; if (reserved !== 16'h0) begin failures++; $display("FAIL rel_clear got=%h exp=0000", reserved); end
    checks++; if (err_pulses !== e0) begin failures++; $display("FAIL rel_no_err got=%0d exp=%0d", err_pulses, e0); end
    press(B_U); press(B_C); press(B_U);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL midrst_pend got=%0d exp=1", state); end
    rst = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", state); end
    checks++; if (reserved !== 16'h0) begin failures++; $display("FAIL midrst_flags got=%h exp=0000", reserved); end
    checks++; if (cursor !== 4'd0) begin failures++; $display("FAIL midrst_cursor got=%0d exp=0", cursor); end
    checks++; if (free_count !== 5'd16) begin failures++; $display("FAIL midrst_free got=%0d exp=16", free_count); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_cursor;
    test_reserve;
    test_autoclear;
    test_err;
    test_timeout;
    test_bounce;
    test_priority;
    test_release_and_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
